// File: rtl/pwm_fade_ctrl_pkg.sv
// Shared definitions for the pwm fade sequencer: duty width, pwm period and fade FSM states.
package pwm_pkg;
  localparam int DUTY_W     = 8;
  localparam int PWM_PERIOD = 256;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } fade_state_e;
endpackage

// File: rtl/pwm_fade_ctrl_if.sv
// Fade command channel: valid/ready handshake carrying target duty and step interval.
interface pwm_fade_ctrl_if #(parameter int RATE_W = 16);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_target;
  logic [RATE_W-1:0] cmd_rate;

  modport master (output cmd_valid, output cmd_target, output cmd_rate, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_target, input cmd_rate, output cmd_ready);
endinterface

// File: rtl/pwm_fade_ctrl_prescaler.sv
// Step-rate prescaler: counts enabled clocks and ticks when the count reaches rate-1, then wraps.
module pwm_fade_prescaler #(
  parameter int RATE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [RATE_W-1:0] i_rate,
  output logic              o_tick
);
  logic [RATE_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == (i_rate - {{(RATE_W-1){1'b0}}, 1'b1}));

  // Cycle counter, cleared while idle so the first step lands rate cycles after acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {RATE_W{1'b0}};
    end else if (i_clr || o_tick) begin
      r_cnt <= {RATE_W{1'b0}};
    end else if (i_en) begin
      r_cnt <= r_cnt + {{(RATE_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end
endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle fade sequencer for the 8-bit pwm core.
// Optional PWM_FADE_PERIOD_SYNC_EN defers every duty change to the pwm period wrap.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int                STEP      = 1,
  parameter int                RATE_W    = 16,
  parameter logic [DUTY_W-1:0] INIT_DUTY = 8'd0
) (
  input  logic              clk,
  input  logic              rst,
  pwm_fade_ctrl_if.slave    cmd,
  input  logic              abort,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done
);
  fade_state_e       r_state, w_state_nx;
  logic [7:0]        r_duty, w_duty_nx;
  logic [7:0]        r_target, w_target_nx;
  logic [RATE_W-1:0] r_rate, w_rate_nx;
  logic              r_done, w_done_nx;
  logic              w_tick;
  logic [7:0]        w_step;
`ifdef PWM_FADE_PERIOD_SYNC_EN
  logic [7:0]        r_pcnt;
  logic              r_pend, w_pend_nx;
  logic [7:0]        r_pend_duty, w_pend_duty_nx;
  logic              w_wrap;
  logic [7:0]        w_cand;
`endif

  // One STEP toward tgt in 9 bits, clamped to tgt so it never overshoots or wraps
  function automatic logic [7:0] f_step(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] up;
    logic [8:0] dn;
    up = {1'b0, cur} + 9'(STEP);
    dn = {1'b0, cur} - 9'(STEP);
    if (tgt > cur) begin
      f_step = (up >= {1'b0, tgt}) ? tgt : up[7:0];
    end else if (tgt < cur) begin
      f_step = (dn[8] || (dn[7:0] <= tgt)) ? tgt : dn[7:0];
    end else begin
      f_step = cur;
    end
  endfunction

  pwm_fade_prescaler #(.RATE_W(RATE_W)) u_presc (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (r_state == IDLE),
    .i_en   (r_state == RAMP),
    .i_rate (r_rate),
    .o_tick (w_tick)
  );

  assign w_step        = f_step(r_duty, r_target);
  assign cmd.cmd_ready = (r_state == IDLE);
  assign busy          = (r_state == RAMP);
  assign duty          = r_duty;
  assign done          = r_done;
`ifdef PWM_FADE_PERIOD_SYNC_EN
  assign w_wrap = (r_pcnt == 8'(PWM_PERIOD - 1));
  assign w_cand = r_pend ? r_pend_duty : w_step;
`endif

  // Next-state, next-duty and done decode
  always_comb begin
    w_state_nx  = r_state;
    w_duty_nx   = r_duty;
    w_target_nx = r_target;
    w_rate_nx   = r_rate;
    w_done_nx   = 1'b0;
`ifdef PWM_FADE_PERIOD_SYNC_EN
    w_pend_nx      = r_pend;
    w_pend_duty_nx = r_pend_duty;
`endif
    case (r_state)
      IDLE: begin
        if (cmd.cmd_valid) begin
          w_target_nx = cmd.cmd_target;
          w_rate_nx   = cmd.cmd_rate;
          if (cmd.cmd_target == r_duty) begin
            w_done_nx = 1'b1;
          end else if (cmd.cmd_rate == {RATE_W{1'b0}}) begin
`ifdef PWM_FADE_PERIOD_SYNC_EN
            // An immediate jump still waits for the period wrap
            w_state_nx     = RAMP;
            w_pend_nx      = 1'b1;
            w_pend_duty_nx = cmd.cmd_target;
`else
            w_duty_nx = cmd.cmd_target;
            w_done_nx = 1'b1;
`endif
          end else begin
            w_state_nx = RAMP;
          end
        end else begin
          w_state_nx = IDLE;
        end
      end
      RAMP: begin
        if (abort) begin
          w_state_nx = IDLE;
`ifdef PWM_FADE_PERIOD_SYNC_EN
          w_pend_nx = 1'b0;
`endif
        end else begin
`ifdef PWM_FADE_PERIOD_SYNC_EN
          if (w_wrap && (r_pend || w_tick)) begin
            w_duty_nx = w_cand;
            w_pend_nx = 1'b0;
            if (w_cand == r_target) begin
              w_state_nx = IDLE;
              w_done_nx  = 1'b1;
            end else begin
              w_state_nx = RAMP;
            end
          end else if (w_tick && !r_pend) begin
            w_pend_nx      = 1'b1;
            w_pend_duty_nx = w_step;
          end else begin
            w_pend_nx = r_pend;
          end
`else
          if (w_tick) begin
            w_duty_nx = w_step;
            if (w_step == r_target) begin
              w_state_nx = IDLE;
              w_done_nx  = 1'b1;
            end else begin
              w_state_nx = RAMP;
            end
          end else begin
            w_duty_nx = r_duty;
          end
`endif
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty   <= INIT_DUTY;
      r_target <= INIT_DUTY;
      r_rate   <= {RATE_W{1'b0}};
      r_done   <= 1'b0;
`ifdef PWM_FADE_PERIOD_SYNC_EN
      r_pcnt      <= 8'd0;
      r_pend      <= 1'b0;
      r_pend_duty <= 8'd0;
`endif
    end else begin
      r_duty   <= w_duty_nx;
      r_target <= w_target_nx;
      r_rate   <= w_rate_nx;
      r_done   <= w_done_nx;
`ifdef PWM_FADE_PERIOD_SYNC_EN
      r_pcnt      <= r_pcnt + 8'd1;
      r_pend      <= w_pend_nx;
      r_pend_duty <= w_pend_duty_nx;
`endif
    end
  end
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: a STEP=1 instance (a) and a STEP=16 instance (b).
module tb_pwm_fade_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_fade_ctrl_if #(.RATE_W(16)) if_a ();
  pwm_fade_ctrl_if #(.RATE_W(16)) if_b ();
  logic       abort_a, abort_b;
  logic [7:0] duty_a, duty_b;
  logic       busy_a, busy_b, done_a, done_b;

  pwm_fade_ctrl #(.STEP(1), .RATE_W(16), .INIT_DUTY(8'd0)) u_a (
    .clk(clk), .rst(rst), .cmd(if_a.slave), .abort(abort_a),
    .duty(duty_a), .busy(busy_a), .done(done_a));
  pwm_fade_ctrl #(.STEP(16), .RATE_W(16), .INIT_DUTY(8'd0)) u_b (
    .clk(clk), .rst(rst), .cmd(if_b.slave), .abort(abort_b),
    .duty(duty_b), .busy(busy_b), .done(done_b));

  int total = 0;
  int bad   = 0;
  int ecnt;
  logic [7:0] seq[$];
  int         seq_cyc[$];

  typedef struct {
    int          sel;
    logic [7:0]  tgt;
    logic [15:0] rate;
    int          lat;
    logic [7:0]  dut;
    int          bsy;
  } vec_t;
  vec_t vecs[10];

  always @(posedge clk) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] d_of(input int sel);
    return (sel != 0) ? duty_b : duty_a;
  endfunction
  function automatic logic b_of(input int sel);
    return (sel != 0) ? busy_b : busy_a;
  endfunction
  function automatic logic dn_of(input int sel);
    return (sel != 0) ? done_b : done_a;
  endfunction
  function automatic logic r_of(input int sel);
    return (sel != 0) ? if_b.cmd_ready : if_a.cmd_ready;
  endfunction

  // Called at a negedge; the acceptance edge is the following posedge.
  task automatic send(input int sel, input logic [7:0] t, input logic [15:0] r);
    if (sel != 0) begin
      if_b.cmd_valid = 1'b1; if_b.cmd_target = t; if_b.cmd_rate = r;
    end else begin
      if_a.cmd_valid = 1'b1; if_a.cmd_target = t; if_a.cmd_rate = r;
    end
    @(negedge clk);
    if_a.cmd_valid = 1'b0;
    if_b.cmd_valid = 1'b0;
  endtask

  // lat = edges after the acceptance edge until done is seen (-1 on timeout)
  task automatic wait_done(input int sel, input logic [7:0] prev_in, input int budget,
                           output int lat, output int busy_seen, output int overlap,
                           output int rdy_at, output int bsy_at);
    logic [7:0] prev;
    prev = prev_in; lat = -1; busy_seen = 0; overlap = 0; rdy_at = 0; bsy_at = 1;
    seq.delete(); seq_cyc.delete();
    for (int k = 0; k <= budget; k++) begin
      if (d_of(sel) != prev) begin
        seq.push_back(d_of(sel)); seq_cyc.push_back(ecnt); prev = d_of(sel);
      end
      if (b_of(sel)) busy_seen = 1;
      if (b_of(sel) && dn_of(sel)) overlap = 1;
      if (dn_of(sel)) begin
        lat = k; rdy_at = int'(r_of(sel)); bsy_at = int'(b_of(sel));
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_cmd(input string nm, input int sel, input logic [7:0] t,
                         input logic [15:0] r, input int exp_lat, input logic [7:0] exp_d,
                         input int exp_bsy);
    int lat, bs, ov, rdy, bsy;
    logic [7:0] p;
    p = d_of(sel);
    chk({nm, "_ready_before"}, int'(r_of(sel)), 1);
    send(sel, t, r);
    wait_done(sel, p, exp_lat + 64, lat, bs, ov, rdy, bsy);
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_duty"}, int'(d_of(sel)), int'(exp_d));
    chk({nm, "_busy_seen"}, bs, exp_bsy);
    chk({nm, "_ready_busy_at_done"}, rdy * 2 + bsy, 2);
    chk({nm, "_done_busy_overlap"}, ov, 0);
  endtask

  initial begin
    int changed;
    int lat, bs, ov, rdy, bsy;
    logic [7:0] exp_up[7];
    logic [7:0] exp_dn[7];
    exp_up = '{8'd16, 8'd32, 8'd48, 8'd64, 8'd80, 8'd96, 8'd100};
    exp_dn = '{8'd84, 8'd68, 8'd52, 8'd36, 8'd20, 8'd4, 8'd0};

    vecs[0] = '{0, 8'd128, 16'd10, 1280, 8'd128, 1};
    vecs[1] = '{0, 8'd128, 16'd5,  0,    8'd128, 0};
    vecs[2] = '{0, 8'd120, 16'd1,  8,    8'd120, 1};
    vecs[3] = '{0, 8'd200, 16'd0,  0,    8'd200, 0};
    vecs[4] = '{0, 8'd200, 16'd0,  0,    8'd200, 0};
    vecs[5] = '{0, 8'd203, 16'd3,  9,    8'd203, 1};
    vecs[6] = '{0, 8'd0,   16'd0,  0,    8'd0,   0};
    vecs[7] = '{1, 8'd255, 16'd1,  16,   8'd255, 1};
    vecs[8] = '{1, 8'd250, 16'd2,  2,    8'd250, 1};
    vecs[9] = '{1, 8'd250, 16'd9,  0,    8'd250, 0};

    if_a.cmd_valid = 1'b0; if_a.cmd_target = 8'd0; if_a.cmd_rate = 16'd0;
    if_b.cmd_valid = 1'b0; if_b.cmd_target = 8'd0; if_b.cmd_rate = 16'd0;
    abort_a = 1'b0; abort_b = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_duty", int'(duty_a), 0);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_done", int'(done_a), 0);
    chk("reset_ready", int'(if_a.cmd_ready), 1);
    rst = 1'b0;

    changed = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (duty_a != 8'd0 || busy_a || done_a || !if_a.cmd_ready ||
          duty_b != 8'd0 || busy_b || done_b || !if_b.cmd_ready) changed = 1;
    end
    chk("idle_hold", changed, 0);

`ifdef PWM_FADE_PERIOD_SYNC_EN
    send(0, 8'd3, 16'd1);
    wait_done(0, 8'd0, 1000, lat, bs, ov, rdy, bsy);
    chk("sync_duty", int'(duty_a), 3);
    chk("sync_nchanges", seq.size(), 3);
    if (seq.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("sync_value", int'(seq[k]), k + 1);
        chk("sync_on_wrap", seq_cyc[k] % 256, 0);
      end
      chk("sync_spacing", seq_cyc[2] - seq_cyc[1], 256);
      chk("sync_done_aligned", ecnt, seq_cyc[2]);
    end
    chk("sync_ready_at_done", rdy, 1);
`else
    // STEP=16 up then down, with exact duty sequences
    send(1, 8'd100, 16'd4);
    wait_done(1, 8'd0, 200, lat, bs, ov, rdy, bsy);
    chk("up16_latency", lat, 28);
    chk("up16_len", seq.size(), 7);
    if (seq.size() == 7)
      for (int k = 0; k < 7; k++) chk("up16_seq", int'(seq[k]), int'(exp_up[k]));
    send(1, 8'd0, 16'd4);
    wait_done(1, 8'd100, 200, lat, bs, ov, rdy, bsy);
    chk("dn16_latency", lat, 28);
    chk("dn16_len", seq.size(), 7);
    if (seq.size() == 7)
      for (int k = 0; k < 7; k++) chk("dn16_seq", int'(seq[k]), int'(exp_dn[k]));

    for (int i = 0; i < 10; i++)
      run_cmd($sformatf("vec%0d", i), vecs[i].sel, vecs[i].tgt, vecs[i].rate,
              vecs[i].lat, vecs[i].dut, vecs[i].bsy);

    // Abort mid-ramp at duty 50
    send(0, 8'd255, 16'd2);
    lat = -1;
    for (int k = 0; k < 300; k++) begin
      if (duty_a == 8'd50) begin lat = k; break; end
      @(negedge clk);
    end
    chk("abort_reach50", lat, 100);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort_duty", int'(duty_a), 50);
    chk("abort_ready", int'(if_a.cmd_ready), 1);
    chk("abort_busy", int'(busy_a), 0);
    changed = 0;
    for (int k = 0; k < 10; k++) begin
      if (done_a || duty_a != 8'd50) changed = 1;
      @(negedge clk);
    end
    chk("abort_frozen", changed, 0);

    // Abort on the same edge as the final step
    send(0, 8'd51, 16'd3);
    @(negedge clk);
    @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort_final_duty", int'(duty_a), 50);
    chk("abort_final_done", int'(done_a), 0);
    chk("abort_final_ready", int'(if_a.cmd_ready), 1);

    // abort together with cmd_valid in IDLE: command wins
    abort_a = 1'b1;
    send(0, 8'd60, 16'd0);
    abort_a = 1'b0;
    chk("abort_idle_done", int'(done_a), 1);
    chk("abort_idle_duty", int'(duty_a), 60);

    // Reset mid-ramp on b (250 -> 0, STEP 16, rate 5)
    send(1, 8'd0, 16'd5);
    repeat (12) @(negedge clk);
    chk("rstmid_pre_duty", int'(duty_b), 218);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_duty", int'(duty_b), 0);
    chk("rstmid_busy", int'(busy_b), 0);
    chk("rstmid_ready", int'(if_b.cmd_ready), 1);
    changed = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done_b || duty_b != 8'd0) changed = 1;
    end
    chk("rstmid_quiet", changed, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
